// File: rtl/rtc_bus_pkg.sv
// Shared constants for the RTC bus controller: state codes, default phase timing,
// bus widths and the power-up INIT write table.
package rtc_bus_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  localparam int T_SETUP_DEF = 2;
  localparam int T_PULSE_DEF = 4;
  localparam int T_HOLD_DEF  = 2;
  localparam int T_GAP_DEF   = 2;

  localparam logic [3:0] ST_INIT  = 4'd0;
  localparam logic [3:0] ST_IDLE  = 4'd1;
  localparam logic [3:0] ST_A_SET = 4'd2;
  localparam logic [3:0] ST_A_STB = 4'd3;
  localparam logic [3:0] ST_A_HLD = 4'd4;
  localparam logic [3:0] ST_GAP   = 4'd5;
  localparam logic [3:0] ST_D_SET = 4'd6;
  localparam logic [3:0] ST_D_STB = 4'd7;
  localparam logic [3:0] ST_D_HLD = 4'd8;
  localparam logic [3:0] ST_DONE  = 4'd9;

  // Both INIT writes target the control register: soft reset, then release.
  localparam logic [ADDR_W-1:0] INIT_ADDR = 7'h02;

  function automatic logic [DATA_W-1:0] init_data(input logic idx);
    return idx ? 8'h00 : 8'h10;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter timing each bus phase; expired is high while the count is zero.
module rtc_phase_timer #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Turns each Acceso request into an address+data bus cycle on the RTC pins, ending in one FRW pulse.
// Macro RTC_INIT_EN: after reset, run the two-write soft-reset sequence before the first FRW.
module rtc_bus_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_PULSE = T_PULSE_DEF,
  parameter int T_HOLD  = T_HOLD_DEF,
  parameter int T_GAP   = T_GAP_DEF
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              Acceso,
  input  logic              Mod,
  input  logic [ADDR_W-1:0] Dir,
  input  logic [DATA_W-1:0] DatoEsc,
  output logic              FRW,
  output logic [DATA_W-1:0] DatoLeido,
  output logic              Ocupado,
  output logic              CS_n,
  output logic              RD_n,
  output logic              WR_n,
  output logic              AD,
  output logic [DATA_W-1:0] AD_out,
  output logic              AD_oe,
  input  logic [DATA_W-1:0] AD_in
);

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(T_GAP - 1);

  logic [3:0]        state, state_nxt;
  logic              tmr_load, tmr_exp;
  logic [CNT_W-1:0]  tmr_val;
  logic              acceso_q, start;
  logic              mod_q;
  logic [ADDR_W-1:0] dir_q;
  logic [DATA_W-1:0] dat_q;
`ifdef RTC_INIT_EN
  logic              init_busy, init_idx;
`endif

  assign start = Acceso & ~acceso_q & (state == ST_IDLE);

  rtc_phase_timer #(.W(CNT_W)) u_timer (
    .CLK      (CLK),
    .RST_n    (RST_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  // The timer is reloaded on the same edge that enters each timed phase.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state)
      ST_INIT: begin
`ifdef RTC_INIT_EN
        state_nxt = ST_A_SET;
        tmr_load  = 1'b1;
        tmr_val   = LD_SETUP;
`else
        state_nxt = ST_DONE;
`endif
      end
      ST_IDLE:  if (start)   begin state_nxt = ST_A_SET; tmr_load = 1'b1; tmr_val = LD_SETUP; end
      ST_A_SET: if (tmr_exp) begin state_nxt = ST_A_STB; tmr_load = 1'b1; tmr_val = LD_PULSE; end
      ST_A_STB: if (tmr_exp) begin state_nxt = ST_A_HLD; tmr_load = 1'b1; tmr_val = LD_HOLD;  end
      ST_A_HLD: if (tmr_exp) begin state_nxt = ST_GAP;   tmr_load = 1'b1; tmr_val = LD_GAP;   end
      ST_GAP:   if (tmr_exp) begin state_nxt = ST_D_SET; tmr_load = 1'b1; tmr_val = LD_SETUP; end
      ST_D_SET: if (tmr_exp) begin state_nxt = ST_D_STB; tmr_load = 1'b1; tmr_val = LD_PULSE; end
      ST_D_STB: if (tmr_exp) begin state_nxt = ST_D_HLD; tmr_load = 1'b1; tmr_val = LD_HOLD;  end
      ST_D_HLD: if (tmr_exp) begin
        state_nxt = ST_DONE;
`ifdef RTC_INIT_EN
        if (init_busy && !init_idx) begin
          state_nxt = ST_A_SET;
          tmr_load  = 1'b1;
          tmr_val   = LD_SETUP;
        end
`endif
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state     <= ST_INIT;
      acceso_q  <= 1'b0;
      mod_q     <= 1'b0;
      dir_q     <= '0;
      dat_q     <= '0;
      DatoLeido <= '0;
`ifdef RTC_INIT_EN
      init_busy <= 1'b0;
      init_idx  <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      acceso_q <= Acceso;
      if (start) begin
        mod_q <= Mod;
        dir_q <= Dir;
        dat_q <= DatoEsc;
      end
      if (state == ST_D_STB && tmr_exp && !mod_q) begin
        DatoLeido <= AD_in;
      end
`ifdef RTC_INIT_EN
      if (state == ST_INIT) begin
        mod_q     <= 1'b1;
        dir_q     <= INIT_ADDR;
        dat_q     <= init_data(1'b0);
        init_busy <= 1'b1;
        init_idx  <= 1'b0;
      end else if (state == ST_D_HLD && tmr_exp && init_busy) begin
        if (!init_idx) begin
          init_idx <= 1'b1;
          dat_q    <= init_data(1'b1);
        end else begin
          init_busy <= 1'b0;
        end
      end
`endif
    end
  end

  // Pin levels decode straight from the state register so an async reset idles the bus at once.
  always_comb begin
    CS_n   = 1'b1;
    RD_n   = 1'b1;
    WR_n   = 1'b1;
    AD     = 1'b0;
    AD_oe  = 1'b0;
    AD_out = '0;
    FRW    = 1'b0;
    case (state)
      ST_A_SET, ST_A_STB, ST_A_HLD: begin
        CS_n   = 1'b0;
        AD_oe  = 1'b1;
        AD_out = {1'b0, dir_q};
        WR_n   = (state != ST_A_STB);
      end
      ST_D_SET, ST_D_STB, ST_D_HLD: begin
        AD   = 1'b1;
        CS_n = 1'b0;
        if (mod_q) begin
          AD_oe  = 1'b1;
          AD_out = dat_q;
          WR_n   = (state != ST_D_STB);
        end else begin
          RD_n = (state != ST_D_STB);
        end
      end
      ST_DONE: FRW = 1'b1;
      default: ;
    endcase
  end

  assign Ocupado = RST_n & (state != ST_IDLE);

endmodule
